// File: rtl/bf_tape_pkg.sv
// Shared types and helpers for the brainfuck data-tape memory.
// Pure definitions: no logic, no latency, no flow control.
package bf_tape_pkg;

    localparam int BF_DATA_W = 8;
    localparam int BF_ADDR_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } bf_tape_state_e;

    // Sweep counter width: enough to index DEPTH cells, never narrower than one bit.
    function automatic int bf_cnt_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

`ifdef BF_TAPE_PARITY_EN
    // Even parity over up to 64 data bits; zero-extension leaves the XOR unchanged.
    function automatic logic bf_even_parity(input logic [63:0] d);
        return ^d;
    endfunction
`endif

endpackage

// File: rtl/bf_tape_clear_seq.sv
// Clear sweep sequencer: writes one tape cell per cycle, DEPTH cycles per full sweep, done one cycle after.
// No backpressure: clr_n low restarts the sweep at cell 0 and holds it there while low.
module bf_tape_clear_seq
    import bf_tape_pkg::*;
#(
    parameter int DEPTH          = 65536,
    parameter bit CLEAR_ON_RESET = 1'b1,
    localparam int CNT_W         = bf_cnt_w(DEPTH)
) (
    input  logic             bfup_clk,
    input  logic             reset,
    input  logic             clr_n,
    output logic             busy,
    output logic             done,
    output logic             clr_we,
    output logic [CNT_W-1:0] clr_addr
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

    bf_tape_state_e   r_state;
    bf_tape_state_e   w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_boot;

    always_ff @(posedge bfup_clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_boot  <= CLEAR_ON_RESET;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
            r_boot  <= 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        clr_we      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!clr_n || r_boot) begin
                    w_state_nxt = CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                // A restart request costs its own cycle and writes nothing.
                if (!clr_n) begin
                    w_cnt_nxt = '0;
                end else begin
                    clr_we = 1'b1;
                    if (r_cnt == LAST) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign busy     = (r_state == CLEAR);
    assign done     = r_done;
    assign clr_addr = r_cnt;

endmodule

// File: rtl/bf_tape_memory.sv
// Data-tape RAM: 1-cycle registered read with rvalid, write on strobe edge, same-edge write-through; optional BF_TAPE_PARITY_EN adds a parity bit and perr.
// No backpressure: CPU accesses are dropped while busy, so the CPU must stall on busy.
module bf_tape_memory
    import bf_tape_pkg::*;
#(
    parameter int                DATA_W         = BF_DATA_W,
    parameter int                ADDR_W         = BF_ADDR_W,
    parameter int                DEPTH          = 65536,
    parameter logic [DATA_W-1:0] FILL           = '0,
    parameter bit                CLEAR_ON_RESET = 1'b1
) (
    input  logic              bfup_clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic              clr_n,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              busy,
    output logic              done,
    output logic              oob
`ifdef BF_TAPE_PARITY_EN
    ,
    output logic              perr
`endif
);

    localparam int CNT_W = bf_cnt_w(DEPTH);
`ifdef BF_TAPE_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    logic [MEM_W-1:0]  r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;
    logic              r_oob;

    logic              w_clr_we;
    logic [CNT_W-1:0]  w_clr_addr;
    logic              w_in_range;
    logic [CNT_W-1:0]  w_idx;
    logic              w_rd;
    logic              w_wr_cpu;
    logic              w_we;
    logic [CNT_W-1:0]  w_waddr;
    logic [DATA_W-1:0] w_wdat;
    logic [MEM_W-1:0]  w_wcell;
    logic [MEM_W-1:0]  w_cell;

    bf_tape_clear_seq #(
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .bfup_clk (bfup_clk),
        .reset    (reset),
        .clr_n    (clr_n),
        .busy     (busy),
        .done     (done),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr)
    );

    // Out-of-range addresses never alias onto a real cell.
    assign w_in_range = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
    assign w_idx      = addr[CNT_W-1:0];
    assign w_rd       = !rd_n && !busy;
    assign w_wr_cpu   = !wr_n && !busy && w_in_range;

    assign w_we    = w_clr_we || w_wr_cpu;
    assign w_waddr = w_clr_we ? w_clr_addr : w_idx;
    assign w_wdat  = w_clr_we ? FILL : wdata;
`ifdef BF_TAPE_PARITY_EN
    assign w_wcell = {bf_even_parity(64'(w_wdat)), w_wdat};
`else
    assign w_wcell = w_wdat;
`endif
    assign w_cell  = r_mem[w_idx];

    always_ff @(posedge bfup_clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wcell;
        end
    end

    always_ff @(posedge bfup_clk or negedge reset) begin
        if (!reset) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_oob    <= 1'b0;
        end else begin
            r_rvalid <= w_rd;
            r_oob    <= !busy && (!rd_n || !wr_n) && !w_in_range;
            if (w_rd) begin
                if (!w_in_range) begin
                    r_rdata <= '0;
                end else if (!wr_n) begin
                    r_rdata <= wdata;
                end else begin
                    r_rdata <= w_cell[DATA_W-1:0];
                end
            end
        end
    end

`ifdef BF_TAPE_PARITY_EN
    logic r_perr;

    always_ff @(posedge bfup_clk or negedge reset) begin
        if (!reset) begin
            r_perr <= 1'b0;
        end else begin
            r_perr <= w_rd && w_in_range && wr_n &&
                      (w_cell[DATA_W] != bf_even_parity(64'(w_cell[DATA_W-1:0])));
        end
    end

    assign perr = r_perr;
`endif

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
    assign oob    = r_oob;

endmodule

// File: tb/tb_bf_tape_memory.sv
// Directed bench for bf_tape_memory: instance A sweeps on reset, instance B does not.
module tb_bf_tape_memory;

    logic       clk = 1'b0;
    logic       reset_a = 1'b0;
    logic       reset_b = 1'b0;
    logic [7:0] addr = '0;
    logic [7:0] wdata = '0;
    logic       rd_n = 1'b1;
    logic       wr_n = 1'b1;
    logic       clr_n_a = 1'b1;
    logic       clr_n_b = 1'b1;

    logic [7:0] rdata_a, rdata_b;
    logic       rvalid_a, rvalid_b, busy_a, busy_b, done_a, done_b, oob_a, oob_b;
`ifdef BF_TAPE_PARITY_EN
    logic       perr_a, perr_b;
`endif

    int total = 0;
    int bad   = 0;
    int nb, nd, lastb, didx;
    bit stall;
    logic [7:0] exp_mem [16];

    always #5 clk = ~clk;

    bf_tape_memory #(
        .DATA_W(8), .ADDR_W(8), .DEPTH(16), .FILL(8'hAA), .CLEAR_ON_RESET(1'b1)
    ) u_a (
        .bfup_clk(clk), .reset(reset_a), .addr(addr), .wdata(wdata),
        .rd_n(rd_n), .wr_n(wr_n), .clr_n(clr_n_a),
        .rdata(rdata_a), .rvalid(rvalid_a), .busy(busy_a), .done(done_a), .oob(oob_a)
`ifdef BF_TAPE_PARITY_EN
        , .perr(perr_a)
`endif
    );

    bf_tape_memory #(
        .DATA_W(8), .ADDR_W(8), .DEPTH(16), .FILL(8'hAA), .CLEAR_ON_RESET(1'b0)
    ) u_b (
        .bfup_clk(clk), .reset(reset_b), .addr(addr), .wdata(wdata),
        .rd_n(rd_n), .wr_n(wr_n), .clr_n(clr_n_b),
        .rdata(rdata_b), .rvalid(rvalid_b), .busy(busy_b), .done(done_b), .oob(oob_b)
`ifdef BF_TAPE_PARITY_EN
        , .perr(perr_b)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state of A
        repeat (3) tick();
        chk("rst_rdata", rdata_a, 0);
        chk("rst_rvalid", rvalid_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_oob", oob_a, 0);

        // Auto sweep after reset release
        reset_a = 1'b1;
        nb = 0; nd = 0; lastb = -1; didx = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy_a) begin nb++; lastb = i; end
            if (done_a) begin nd++; didx = i; end
        end
        chk("sweep_busy_cycles", nb, 16);
        chk("sweep_last_busy", lastb, 15);
        chk("sweep_done_pulses", nd, 1);
        chk("sweep_done_pos", didx, 16);

        for (int i = 0; i < 16; i++) exp_mem[i] = 8'hAA;
        for (int i = 0; i < 16; i++) begin
            addr = 8'(i); rd_n = 1'b0;
            tick();
            chk($sformatf("fill_rvalid%0d", i), rvalid_a, 1);
            chk($sformatf("fill_rdata%0d", i), rdata_a, 8'hAA);
        end
        rd_n = 1'b1;
        tick();
        chk("rvalid_idle", rvalid_a, 0);

        // Write then read
        addr = 8'd5; wdata = 8'h42; wr_n = 1'b0;
        tick();
        chk("wr_no_rvalid", rvalid_a, 0);
        exp_mem[5] = 8'h42;
        wr_n = 1'b1; rd_n = 1'b0;
        tick();
        chk("rd5_rvalid", rvalid_a, 1);
        chk("rd5_rdata", rdata_a, 8'h42);
        rd_n = 1'b1;
        tick();
        chk("rd5_rvalid_drop", rvalid_a, 0);
        chk("rd5_rdata_hold", rdata_a, 8'h42);

        // Same-edge read and write: write-through
        addr = 8'd7; wdata = 8'h99; rd_n = 1'b0; wr_n = 1'b0;
        tick();
        chk("wt_rvalid", rvalid_a, 1);
        chk("wt_rdata", rdata_a, 8'h99);
        exp_mem[7] = 8'h99;
        wr_n = 1'b1; wdata = 8'h00;
        tick();
        chk("wt_reread", rdata_a, 8'h99);
        rd_n = 1'b1;

        // Out of range: no write, zero read data, oob pulses
        addr = 8'd20; wdata = 8'h55; wr_n = 1'b0;
        tick();
        chk("oob_wr_pulse", oob_a, 1);
        wr_n = 1'b1;
        tick();
        chk("oob_wr_clear", oob_a, 0);
        rd_n = 1'b0;
        tick();
        chk("oob_rd_pulse", oob_a, 1);
        chk("oob_rd_rvalid", rvalid_a, 1);
        chk("oob_rd_rdata", rdata_a, 0);
        rd_n = 1'b1;
        tick();
        chk("oob_rd_clear", oob_a, 0);
        for (int i = 0; i < 16; i++) begin
            addr = 8'(i); rd_n = 1'b0;
            tick();
            chk($sformatf("oob_cell%0d", i), rdata_a, 32'(exp_mem[i]));
        end
        addr = 8'd5;
        tick();
        chk("pre_sweep_rd5", rdata_a, 8'h42);
        rd_n = 1'b1;

        // Restart on clr_n in the 6th busy cycle; CPU access during busy is ignored
        clr_n_a = 1'b0;
        tick();
        clr_n_a = 1'b1;
        nb = 0; nd = 0; stall = 1'b0;
        for (int i = 0; i < 60; i++) begin
            clr_n_a = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
            if (busy_a) begin
                if (nb == 5) clr_n_a = 1'b0;
                if (nb == 15) begin
                    addr = 8'd3; wdata = 8'h77; wr_n = 1'b0; rd_n = 1'b0; stall = 1'b1;
                end
                nb++;
            end
            tick();
            if (done_a) nd++;
            if (stall) begin
                chk("stall_rvalid", rvalid_a, 0);
                chk("stall_rdata_hold", rdata_a, 8'h42);
                stall = 1'b0;
            end
        end
        clr_n_a = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
        chk("restart_busy_cycles", nb, 22);
        chk("restart_done_pulses", nd, 1);
        addr = 8'd3; rd_n = 1'b0;
        tick();
        chk("stall_cell3", rdata_a, 8'hAA);
        addr = 8'd5;
        tick();
        chk("resweep_cell5", rdata_a, 8'hAA);
        rd_n = 1'b1;

        // Instance B: reset in the middle of a manual sweep
        reset_b = 1'b1;
        tick();
        tick();
        chk("b_no_autosweep", busy_b, 0);
        wdata = 8'h11; wr_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            addr = 8'(i);
            tick();
        end
        wr_n = 1'b1;
        clr_n_b = 1'b0;
        tick();
        clr_n_b = 1'b1;
        chk("b_busy_start", busy_b, 1);
        repeat (4) tick();
        reset_b = 1'b0;
        #1;
        chk("b_busy_async_drop", busy_b, 0);
        chk("b_done_after_abort", done_b, 0);
        tick();
        reset_b = 1'b1;
        tick();
        chk("b_idle_after_reset", busy_b, 0);
        for (int i = 0; i < 16; i++) begin
            addr = 8'(i); rd_n = 1'b0;
            tick();
            chk($sformatf("b_rvalid%0d", i), rvalid_b, 1);
            chk($sformatf("b_cell%0d", i), rdata_b, (i < 4) ? 8'hAA : 8'h11);
        end
        rd_n = 1'b1;
        tick();

`ifdef BF_TAPE_PARITY_EN
        addr = 8'd2; wdata = 8'h03; wr_n = 1'b0;
        tick();
        wr_n = 1'b1;
        force u_a.r_mem[2][8] = 1'b1;
        rd_n = 1'b0;
        tick();
        chk("par_bad_perr", perr_a, 1);
        chk("par_bad_rvalid", rvalid_a, 1);
        chk("par_bad_rdata", rdata_a, 8'h03);
        release u_a.r_mem[2][8];
        addr = 8'd5;
        tick();
        chk("par_clean_perr", perr_a, 0);
        chk("par_clean_rvalid", rvalid_a, 1);
        rd_n = 1'b1;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bf_tape_memory.md
Name: bf_tape_memory

Overview:
- Parametrised data-tape RAM for brainfuck_uP; next generation of the fixed 64K×8 data memory.
- Adds configurable width and depth, registered reads with a valid flag, and a sequential clear engine with busy/done.
- Adds out-of-range detection and optional auto-clear after reset.
- Sits between the CPU's p/pData/RD/WR pins and the tape storage. Data in and data out are split; the top level builds any tri-state pData.

Parameters:
- DATA_W, 8: cell width in bits.
- ADDR_W, 16: address width.
- DEPTH, 65536: implemented cells; must satisfy 1 ≤ DEPTH ≤ 2^ADDR_W.
- FILL, 0: value written by the clear sweep (DATA_W bits).
- CLEAR_ON_RESET, 1: if 1, a sweep starts automatically on the first edge after reset deasserts.

Ports:
- bfup_clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- addr  in  ADDR_W  cell address (the CPU's p).
- wdata  in  DATA_W  write data.
- rd_n  in  1  active-low read strobe, sampled on the rising edge.
- wr_n  in  1  active-low write strobe, sampled on the rising edge.
- clr_n  in  1  active-low clear request, sampled on the rising edge.
- rdata  out  DATA_W  registered read data.
- rvalid  out  1  rdata was updated on the last edge.
- busy  out  1  clear sweep in progress.
- done  out  1  one-cycle pulse after the last cell is cleared.
- oob  out  1  one-cycle pulse when an access had addr ≥ DEPTH.

Behaviour:
- Reset (reset=0, async): rdata=0, rvalid=0, busy=0, done=0, oob=0; FSM → IDLE; sweep counter=0. Array contents are not touched by reset.
- FSM states: IDLE, CLEAR.
  - IDLE→CLEAR on clr_n=0, or on the first edge after reset release when CLEAR_ON_RESET=1.
  - In CLEAR, one cell per edge: mem[cnt]<=FILL, cnt increments.
  - At cnt=DEPTH-1: write that cell, go to IDLE, done=1 for the next cycle. A full sweep takes exactly DEPTH cycles.
  - busy=1 in CLEAR.
- clr_n=0 while in CLEAR: cnt restarts at 0. clr_n held low holds the sweep at cell 0 until released.
- CPU accesses while busy=1 are ignored: no write, rvalid=0, rdata holds its value. The CPU must stall on busy.
- Read: rd_n=0 at edge N → rdata=mem[addr] and rvalid=1 after edge N. Latency 1; rvalid is 0 in every other cycle.
- Write: wr_n=0 at edge N → mem[addr]<=wdata at edge N.
- rd_n=0 and wr_n=0 on the same edge at the same address: the write happens and rdata returns the new wdata (write-through). Different-address simultaneous access cannot occur (single addr bus).
- addr ≥ DEPTH (only possible when DEPTH < 2^ADDR_W):
  - write dropped;
  - a read returns rdata=0 with rvalid=1;
  - oob=1 for one cycle.
  - No address wrap.
- Reset during CLEAR aborts the sweep. Cells not yet cleared keep their old contents. With CLEAR_ON_RESET=1, a fresh sweep starts from 0.
- Sweep counter width is clog2(DEPTH), minimum 1. The compare uses DEPTH-1 exactly; the counter never exceeds it.

Optional Feature:
- Macro BF_TAPE_PARITY_EN.
- Defined:
  - each cell stores one extra even-parity bit, computed on CPU writes and on FILL;
  - adds output perr (1 bit), which pulses for one cycle alongside rvalid when a read's stored parity mismatches.
  - A bench may corrupt a cell's parity through a hierarchical force.
- Undefined: no parity storage and no perr port; array width is exactly DATA_W.

Decomposition:
- Package bf_tape_pkg holds:
  - FSM state enum (IDLE, CLEAR);
  - default-width localparams (BF_DATA_W=8, BF_ADDR_W=16);
  - a parity function, used only under BF_TAPE_PARITY_EN.
- Sub-module bf_tape_clear_seq: owns the FSM, sweep counter, busy and done. Outputs clr_we and clr_addr, which the top muxes over the CPU port. The array and read path stay in bf_tape_memory.

Test Plan:
- Sweep after reset: DEPTH=16, CLEAR_ON_RESET=1, FILL=8'hAA, reset low 3 cycles then high → busy=1 for exactly 16 cycles, then a done pulse; reading addr 0..15 returns 8'hAA with rvalid 1 cycle after each rd_n.
- Write/read: write 8'h42 to addr 5, then rd_n at addr 5 → rdata=8'h42 on the next edge, rvalid=1 for one cycle. Same-edge rd_n+wr_n at addr 7 with wdata=8'h99 → rdata=8'h99.
- Out of range: DEPTH=16, ADDR_W=8, write addr 20 then read addr 20 → oob pulses twice, rdata=0, cells 0..15 unchanged.
- Restart and stall: clr_n pulse at sweep cycle 6 → sweep restarts at 0, total busy = 6+16 cycles. A wr_n during busy leaves its target cell at FILL.
- Reset mid-sweep: CLEAR_ON_RESET=0, preload all cells with 8'h11, clr_n, then assert reset at sweep cycle 4 → busy=0 at once; cells 0..3 = FILL, cells 4..15 = 8'h11.
- Parity (BF_TAPE_PARITY_EN): write 8'h03, force the parity bit to flip, read → perr=1 with rvalid. A clean cell read gives perr=0.
